sync_fifo: RTL and testbench

//  Single-clock show-ahead (first-word-fall-through) FIFO: the storage end of the
//  rd_en/empty and wr_en/full handshake used by every DSP stage in the FM chain.

---
 rtl/sync_fifo.sv | 120 ++++++++++++
 tb/tb_sync_fifo.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead (first-word-fall-through) FIFO. The head word is
// presented on dout whenever the FIFO is not empty, and the consumer pops it by
// asserting rd_en in the same cycle it samples dout.
//
// Build option: define SYNC_FIFO_ERR_EN to enable the sticky overflow/underflow
// flags. When it is undefined, both flags are tied to 0.
//
// Ports
//   clk        in   1            single clock, all logic on posedge
//   rst_n      in   1            asynchronous active-low reset
//   wr_en      in   1            write request, accepted only when !full
//   din        in   DATA_WIDTH   write data
//   full       out  1            no free entry
//   rd_en      in   1            pop request, accepted only when !empty
//   dout       out  DATA_WIDTH   head-of-queue word, 0 while empty
//   empty      out  1            no stored entry
//   count      out  AW+1         occupancy, 0..FIFO_DEPTH
//   overflow   out  1            sticky: write attempted while full
//   underflow  out  1            sticky: read attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         din,
  output logic                          full,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q,  count_d;

  logic wr_acc;
  logic rd_acc;

  // Flags decode only from registered pointers, so there is no combinational
  // path from the request inputs to full/empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW]     != rd_ptr_q[AW]);

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; stale words are hidden by the pointers.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q[AW-1:0]] <= din;
  end

  assign dout  = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
  assign count = count_q;

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q,  overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (wr_en && full);
    underflow_d = underflow_q | (rd_en && empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
// Directed bench for sync_fifo (DATA_WIDTH=32, FIFO_DEPTH=16). Flag expectations
// follow the SYNC_FIFO_ERR_EN build option.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

  localparam int DW = 32;
  localparam int D  = 16;
  localparam int CW = $clog2(D) + 1;

`ifdef SYNC_FIFO_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [DW-1:0] din;
  logic          full;
  logic          rd_en;
  logic [DW-1:0] dout;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  int checks;
  int errors;

  sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .din       (din),
    .full      (full),
    .rd_en     (rd_en),
    .dout      (dout),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic          rd;
    logic [DW-1:0] wdata;
    logic          e;
    logic          f;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic          o;   // flag value expected when error flags are built in
    logic          u;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle, check the async clear while still in reset, then
  // release on a falling edge.
  task automatic do_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst_n = 1'b0;
    #2;
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full",  {31'd0, full},  32'd0);
    check("rst_count", {27'd0, count}, 32'd0);
    check("rst_dout",  dout,           32'd0);
    check("rst_ovf",   {31'd0, overflow},  32'd0);
    check("rst_unf",   {31'd0, underflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    din    = '0;

    //            wr    rd    din       e     f     c      dout      o     u
    vecs[0] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 5'd0, 32'h00, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h11, 1'b0, 1'b0, 5'd1, 32'h11, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h22, 1'b0, 1'b0, 5'd2, 32'h11, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h33, 1'b0, 1'b0, 5'd3, 32'h11, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 32'h00, 1'b0, 1'b0, 5'd2, 32'h22, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 32'h00, 1'b0, 1'b0, 5'd1, 32'h33, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 32'h00, 1'b1, 1'b0, 5'd0, 32'h00, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 32'h5A, 1'b0, 1'b0, 5'd1, 32'h5A, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 32'h66, 1'b0, 1'b0, 5'd1, 32'h66, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 1'b1, 32'h00, 1'b1, 1'b0, 5'd0, 32'h00, 1'b0, 1'b1};

    #12;
    do_reset();

    // Basic write/read, then write+read on empty, then write+read with one word.
    for (int i = 0; i < 10; i++) begin
      wr_en = vecs[i].wr;
      rd_en = vecs[i].rd;
      din   = vecs[i].wdata;
      step();
      check($sformatf("v%0d_empty", i), {31'd0, empty}, {31'd0, vecs[i].e});
      check($sformatf("v%0d_full",  i), {31'd0, full},  {31'd0, vecs[i].f});
      check($sformatf("v%0d_count", i), {27'd0, count}, {27'd0, vecs[i].c});
      check($sformatf("v%0d_dout",  i), dout,           vecs[i].d);
      check($sformatf("v%0d_ovf",   i), {31'd0, overflow},  {31'd0, vecs[i].o & ERR});
      check($sformatf("v%0d_unf",   i), {31'd0, underflow}, {31'd0, vecs[i].u & ERR});
    end
    wr_en = 1'b0;
    rd_en = 1'b0;

    // Fill past capacity: 17th write dropped; then write+read while full.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1;
      din   = 32'h100 + i;
      step();
      check($sformatf("fill%0d_count", i), {27'd0, count}, (i < 16) ? i + 1 : 16);
      check($sformatf("fill%0d_full",  i), {31'd0, full},  (i >= 15) ? 32'd1 : 32'd0);
    end
    wr_en = 1'b0;
    check("fill_ovf", {31'd0, overflow}, {31'd0, ERR});
    check("full_head", dout, 32'h100);
    wr_en = 1'b1;
    rd_en = 1'b1;
    din   = 32'hDEAD;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("full_wr_rd_count", {27'd0, count}, 32'd15);
    check("full_wr_rd_full",  {31'd0, full},  32'd0);
    for (int k = 1; k < 16; k++) begin
      check($sformatf("drain%0d_dout", k), dout, 32'h100 + k);
      rd_en = 1'b1;
      step();
    end
    rd_en = 1'b0;
    check("drain_empty", {31'd0, empty}, 32'd1);
    check("drain_count", {27'd0, count}, 32'd0);
    check("drain_dout",  dout,           32'd0);
    check("drain_unf",   {31'd0, underflow}, 32'd0);

    // Steady state at depth 8 across pointer wrap.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1;
      din   = 32'h200 + i;
      step();
    end
    check("half_count", {27'd0, count}, 32'd8);
    for (int k = 0; k < 40; k++) begin
      wr_en = 1'b1;
      rd_en = 1'b1;
      din   = 32'h208 + k;
      check($sformatf("stream%0d_dout", k), dout, 32'h200 + k);
      step();
      check($sformatf("stream%0d_count", k), {27'd0, count}, 32'd8);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("stream_head", dout, 32'h228);

    // Sticky error flags and reset mid-operation.
    do_reset();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("unf_set", {31'd0, underflow}, {31'd0, ERR});
    check("unf_set_ovf", {31'd0, overflow}, 32'd0);
    step();
    step();
    step();
    check("unf_hold", {31'd0, underflow}, {31'd0, ERR});
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      din   = 32'h300 + i;
      step();
    end
    check("pre_ovf", {31'd0, overflow}, 32'd0);
    din = 32'hBAD;
    step();
    wr_en = 1'b0;
    check("ovf_set",   {31'd0, overflow}, {31'd0, ERR});
    check("ovf_count", {27'd0, count},    32'd16);
    step();
    step();
    check("ovf_hold", {31'd0, overflow},  {31'd0, ERR});
    check("unf_hold2", {31'd0, underflow}, {31'd0, ERR});
    check("ovf_head", dout, 32'h300);
    do_reset();
    step();
    check("post_rst_empty", {31'd0, empty}, 32'd1);
    check("post_rst_count", {27'd0, count}, 32'd0);
    check("post_rst_dout",  dout,           32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
